// File: rtl/imem_boot_ctrl.sv
// Boot/download sequencer: owns the program ROM write port during a UART load,
// packs bytes little-endian into words and holds the CPU in reset until flushed.
module imem_boot_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int WORDS     = 16384,
  parameter int TIMEOUT   = 100000,
  parameter int FLUSH_CYC = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_req_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              rom_sel_o,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [31:0]       rom_wdata_o,
  output logic              cpu_rst_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int FL_W   = $clog2(FLUSH_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {ST_FLUSH, ST_RUN, ST_LOAD, ST_WRITE} state_t;

  state_t              state_q, state_d;
  logic [FL_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                done_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic                req_rise;
  logic                accept;
  logic                rx_ready_q, own_q, rom_we_q, cpu_rst_q, done_q;

  assign req_rise = sync2_q & ~sync3_q;
  assign accept   = rx_valid_i & rx_ready_q;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = '0;
    idle_cnt_d  = idle_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    words_d     = words_q;
    done_d      = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == FL_W'(FLUSH_CYC)) state_d = ST_RUN;
        else flush_cnt_d = flush_cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (req_rise) begin
          state_d    = ST_LOAD;
          addr_d     = '0;
          byte_cnt_d = '0;
          words_d    = '0;
          idle_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wdata_d[8*byte_cnt_q +: 8] = rx_data_i;
          byte_cnt_d = byte_cnt_q + 1'b1;
          idle_cnt_d = '0;
          if (byte_cnt_q == 2'd3) state_d = ST_WRITE;
        end else if (words_q != '0) begin
          // No timeout until the first word has landed; a partial word is dropped.
          if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d = ST_FLUSH;
            done_d  = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        byte_cnt_d = '0;
        idle_cnt_d = '0;
        words_d    = words_q + 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_FLUSH;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  // Output flops are loaded from the next state so every output is registered
  // yet aligned with the state it describes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      idle_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      words_q     <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      rx_ready_q  <= 1'b0;
      own_q       <= 1'b0;
      rom_we_q    <= 1'b0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      words_q     <= words_d;
      sync1_q     <= load_req_i;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      rx_ready_q  <= (state_d == ST_LOAD);
      own_q       <= (state_d == ST_LOAD) || (state_d == ST_WRITE);
      rom_we_q    <= (state_d == ST_WRITE);
      cpu_rst_q   <= (state_d != ST_RUN);
      done_q      <= done_d;
    end
  end

  assign rx_ready_o     = rx_ready_q;
  assign rom_sel_o      = own_q;
  assign load_busy_o    = own_q;
  assign rom_we_o       = rom_we_q;
  assign rom_addr_o     = addr_q;
  assign rom_wdata_o    = wdata_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign load_done_o    = done_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: a main instance (TIMEOUT=20) and a
// two-word instance for the end-of-ROM case.
module tb_imem_boot_ctrl;
  localparam int AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          rst_n, load_req, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, rom_sel, rom_we, cpu_rst, load_busy, load_done;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_wdata;
  logic [AW:0]   words_loaded;

  logic          load_req2, rx_valid2;
  logic [7:0]    rx_data2;
  logic          rx_ready2, rom_sel2, rom_we2, cpu_rst2, load_busy2, load_done2;
  logic [AW-1:0] rom_addr2;
  logic [31:0]   rom_wdata2;
  logic [AW:0]   words_loaded2;

  imem_boot_ctrl #(.ADDR_W(AW), .WORDS(16384), .TIMEOUT(20), .FLUSH_CYC(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .load_req_i(load_req), .rx_valid_i(rx_valid),
    .rx_data_i(rx_data), .rx_ready_o(rx_ready), .rom_sel_o(rom_sel), .rom_we_o(rom_we),
    .rom_addr_o(rom_addr), .rom_wdata_o(rom_wdata), .cpu_rst_o(cpu_rst),
    .load_busy_o(load_busy), .load_done_o(load_done), .words_loaded_o(words_loaded)
  );

  imem_boot_ctrl #(.ADDR_W(AW), .WORDS(2), .TIMEOUT(20), .FLUSH_CYC(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .load_req_i(load_req2), .rx_valid_i(rx_valid2),
    .rx_data_i(rx_data2), .rx_ready_o(rx_ready2), .rom_sel_o(rom_sel2), .rom_we_o(rom_we2),
    .rom_addr_o(rom_addr2), .rom_wdata_o(rom_wdata2), .cpu_rst_o(cpu_rst2),
    .load_busy_o(load_busy2), .load_done_o(load_done2), .words_loaded_o(words_loaded2)
  );

  // ROM write logs, sampled on the falling edge
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  logic [AW-1:0] wa2[$];
  logic [31:0]   wd2[$];
  int cyc = 0;
  int we_rdy_bad = 0;
  int we2_cyc = -100;
  int done2_cyc = -200;

  always @(negedge clk) begin
    cyc++;
    if (rom_we === 1'b1) begin
      wa.push_back(rom_addr);
      wd.push_back(rom_wdata);
      if (rx_ready !== 1'b0) we_rdy_bad++;
    end
    if (rom_we2 === 1'b1) begin
      wa2.push_back(rom_addr2);
      wd2.push_back(rom_wdata2);
      we2_cyc = cyc;
    end
    if (load_done2 === 1'b1) done2_cyc = cyc;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL send_byte_timeout: rx_ready=%b after %0d cycles, want 1", rx_ready, n);
    end
    @(negedge clk);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    repeat (3) @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic wait_load_done(output int n);
    n = 0;
    while (load_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (cpu_rst !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cpu_rst !== 1'b0) begin
      bad++;
      $display("FAIL wait_run: cpu_rst=%b after %0d cycles, want 0", cpu_rst, n);
    end
  endtask

  task automatic test_reset();
    int k;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({cpu_rst, rom_sel, rom_we, rx_ready, load_busy, load_done} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 100000",
                      {cpu_rst, rom_sel, rom_we, rx_ready, load_busy, load_done});
    end
    total++;
    if (rom_addr !== '0 || rom_wdata !== 32'h0 || words_loaded !== '0) begin
      bad++; $display("FAIL reset_data: addr=%h wdata=%h words=%0d want 0", rom_addr, rom_wdata, words_loaded);
    end
    rst_n = 1'b1;
    k = 0;
    @(negedge clk);
    while (cpu_rst === 1'b1 && k < 50) begin
      k++;
      total++;
      if (rom_sel !== 1'b0) begin bad++; $display("FAIL flush_rom_sel: got %b want 0", rom_sel); end
      @(negedge clk);
    end
    total++;
    if (k !== 4) begin bad++; $display("FAIL reset_flush_len: cpu_rst high %0d cycles, want 4", k); end
    repeat (3) @(negedge clk);
    total++;
    if (cpu_rst !== 1'b0 || cpu_rst2 !== 1'b0) begin
      bad++; $display("FAIL run_cpu_rst: got %b/%b want 0/0", cpu_rst, cpu_rst2);
    end
    total++;
    if (wa.size() != 0 || wa2.size() != 0) begin
      bad++; $display("FAIL reset_no_write: writes %0d/%0d want 0", wa.size(), wa2.size());
    end
  endtask

  task automatic test_two_words();
    logic [7:0] bytes [8];
    int n, k;
    bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wa.delete(); wd.delete();
    pulse_load();
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      total++;
      if (cpu_rst !== 1'b1 || load_busy !== 1'b1) begin
        bad++; $display("FAIL load_cpu_rst byte %0d: cpu_rst=%b busy=%b want 1/1", i, cpu_rst, load_busy);
      end
    end
    rx_valid = 1'b0;
    wait_load_done(n);
    total++;
    if (n !== 21) begin bad++; $display("FAIL timeout_latency: load_done after %0d cycles, want 21", n); end
    total++;
    if (words_loaded !== 15'd2 || cpu_rst !== 1'b1) begin
      bad++; $display("FAIL done_state: words=%0d cpu_rst=%b want 2/1", words_loaded, cpu_rst);
    end
    @(negedge clk);
    k = 1;
    total++;
    if (load_done !== 1'b0) begin bad++; $display("FAIL done_pulse: load_done=%b want 0", load_done); end
    while (cpu_rst === 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k !== 5) begin bad++; $display("FAIL done_to_run: cpu_rst fell %0d cycles after done, want 5", k); end
    #1;
    total++;
    if (wa.size() != 2) begin
      bad++; $display("FAIL two_words_count: got %0d want 2", wa.size());
    end else begin
      total++;
      if (wa[0] !== 14'd0 || wd[0] !== 32'h12345678) begin
        bad++; $display("FAIL word0: addr=%0d data=%h want 0/12345678", wa[0], wd[0]);
      end
      total++;
      if (wa[1] !== 14'd1 || wd[1] !== 32'hDEADBEEF) begin
        bad++; $display("FAIL word1: addr=%0d data=%h want 1/deadbeef", wa[1], wd[1]);
      end
    end
  endtask

  task automatic test_words_limit();
    int idx;
    wa2.delete(); wd2.delete();
    load_req2 = 1'b1;
    repeat (3) @(negedge clk);
    load_req2 = 1'b0;
    idx = 0;
    rx_valid2 = 1'b1;
    for (int c = 0; c < 60 && idx < 12; c++) begin
      rx_data2 = 8'(idx);
      if (rx_ready2 === 1'b1) idx++;
      @(negedge clk);
    end
    rx_valid2 = 1'b0;
    #1;
    total++;
    if (idx !== 8) begin bad++; $display("FAIL limit_accepted: got %0d bytes want 8", idx); end
    total++;
    if (wa2.size() != 2) begin
      bad++; $display("FAIL limit_writes: got %0d want 2", wa2.size());
    end else begin
      total++;
      if (wa2[0] !== 14'd0 || wd2[0] !== 32'h03020100 || wa2[1] !== 14'd1 || wd2[1] !== 32'h07060504) begin
        bad++; $display("FAIL limit_data: %0d:%h %0d:%h want 0:03020100 1:07060504",
                        wa2[0], wd2[0], wa2[1], wd2[1]);
      end
    end
    total++;
    if (done2_cyc !== we2_cyc + 1) begin
      bad++; $display("FAIL limit_flush: done at %0d, last write at %0d, want write+1", done2_cyc, we2_cyc);
    end
    total++;
    if (rom_addr2 !== 14'd1 || words_loaded2 !== 15'd2 || rx_ready2 !== 1'b0) begin
      bad++; $display("FAIL limit_final: addr=%0d words=%0d ready=%b want 1/2/0",
                      rom_addr2, words_loaded2, rx_ready2);
    end
  endtask

  task automatic test_partial();
    logic [7:0] bytes [10];
    int n;
    bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hAA, 8'hBB, 8'h11, 8'h22, 8'h33, 8'h44};
    wait_run();
    wa.delete(); wd.delete();
    pulse_load();
    for (int i = 0; i < 6; i++) send_byte(bytes[i]);
    rx_valid = 1'b0;
    wait_load_done(n);
    #1;
    total++;
    if (load_done !== 1'b1 || words_loaded !== 15'd1) begin
      bad++; $display("FAIL partial_done: done=%b words=%0d want 1/1", load_done, words_loaded);
    end
    total++;
    if (wa.size() != 1 || wd[0] !== 32'h12345678) begin
      bad++; $display("FAIL partial_writes: count=%0d data=%h want 1/12345678", wa.size(), wd[0]);
    end
    wait_run();
    wa.delete(); wd.delete();
    pulse_load();
    for (int i = 6; i < 10; i++) send_byte(bytes[i]);
    rx_valid = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (wa.size() != 1 || wa[0] !== 14'd0 || wd[0] !== 32'h44332211) begin
      bad++; $display("FAIL reload_word0: count=%0d addr=%0d data=%h want 1/0/44332211",
                      wa.size(), wa[0], wd[0]);
    end
    wait_load_done(n);
  endtask

  task automatic test_back_to_back();
    int idx, n;
    wait_run();
    wa.delete(); wd.delete();
    we_rdy_bad = 0;
    pulse_load();
    idx = 0;
    rx_valid = 1'b1;
    for (int c = 0; c < 100 && idx < 12; c++) begin
      rx_data = 8'(idx);
      if (rx_ready === 1'b1) idx++;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    wait_load_done(n);
    #1;
    total++;
    if (idx !== 12 || words_loaded !== 15'd3) begin
      bad++; $display("FAIL b2b_count: bytes=%0d words=%0d want 12/3", idx, words_loaded);
    end
    total++;
    if (we_rdy_bad !== 0) begin bad++; $display("FAIL b2b_ready_in_write: got %0d want 0", we_rdy_bad); end
    total++;
    if (wa.size() != 3) begin
      bad++; $display("FAIL b2b_writes: got %0d want 3", wa.size());
    end else begin
      total++;
      if (wd[0] !== 32'h03020100 || wd[1] !== 32'h07060504 || wd[2] !== 32'h0B0A0908) begin
        bad++; $display("FAIL b2b_data: %h %h %h want 03020100 07060504 0b0a0908", wd[0], wd[1], wd[2]);
      end
      total++;
      if (wa[0] !== 14'd0 || wa[1] !== 14'd1 || wa[2] !== 14'd2) begin
        bad++; $display("FAIL b2b_addr: %0d %0d %0d want 0 1 2", wa[0], wa[1], wa[2]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int busy_seen, k;
    wait_run();
    wa.delete(); wd.delete();
    pulse_load();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    rst_n = 1'b0;
    load_req = 1'b1;
    rx_valid = 1'b0;
    #1;
    total++;
    if ({cpu_rst, rom_sel, rom_we, rx_ready, load_busy, load_done} !== 6'b100000) begin
      bad++; $display("FAIL abort_ctrl: got %b want 100000",
                      {cpu_rst, rom_sel, rom_we, rx_ready, load_busy, load_done});
    end
    total++;
    if (rom_addr !== '0 || words_loaded !== '0) begin
      bad++; $display("FAIL abort_data: addr=%0d words=%0d want 0/0", rom_addr, words_loaded);
    end
    total++;
    if (wa.size() != 1 || wa[0] !== 14'd0 || wd[0] !== 32'h04030201) begin
      bad++; $display("FAIL abort_writes: count=%0d addr=%0d data=%h want 1/0/04030201",
                      wa.size(), wa[0], wd[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (load_busy === 1'b1) busy_seen++;
    end
    total++;
    if (busy_seen !== 0 || cpu_rst !== 1'b0) begin
      bad++; $display("FAIL held_req: busy cycles=%0d cpu_rst=%b want 0/0", busy_seen, cpu_rst);
    end
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    load_req = 1'b1;
    k = 0;
    while (load_busy !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (load_busy !== 1'b1 || rom_sel !== 1'b1) begin
      bad++; $display("FAIL toggled_req: busy=%b sel=%b want 1/1", load_busy, rom_sel);
    end
    load_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    load_req2 = 1'b0; rx_valid2 = 1'b0; rx_data2 = 8'h00;
    test_reset();
    test_two_words();
    test_words_limit();
    test_partial();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot/download sequencer for the program ROM feeding the instruction-fetch unit. In RUN it leaves the ROM to the fetch path and holds the CPU out of reset. On a load request it holds the CPU in reset and takes ownership of the ROM write port. It then assembles a byte stream (from the UART receiver) into 32-bit little-endian words and writes them to consecutive word addresses from 0. When the load ends it flushes and releases the CPU so fetch restarts at PC 0.

Parameters:
ADDR_W, 14, ROM word-address width (matches PC[15:2] addressing)
WORDS, 16384, maximum words per load; load ends after word WORDS-1 is written
TIMEOUT, 100000, idle cycles with no accepted byte (after ≥1 word written) that end a load
FLUSH_CYC, 4, cycles cpu_rst is held after a load ends, or after reset deasserts

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
load_req  in  1  asynchronous download request (switch); synchronised internally
rx_valid  in  1  byte available from the UART receiver
rx_data  in  8  received byte
rx_ready  out  1  byte accepted when rx_valid && rx_ready
rom_sel  out  1  1 = ROM port driven by this block, 0 = fetch path
rom_we  out  1  one-cycle ROM write strobe
rom_addr  out  ADDR_W  ROM word address
rom_wdata  out  32  ROM write data
cpu_rst  out  1  active-high reset to the fetch unit and the rest of the CPU
load_busy  out  1  high in LOAD and WRITE
load_done  out  1  one-cycle pulse on entry to FLUSH from a load
words_loaded  out  ADDR_W+1  words written by the last load; held until the next load starts

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state FLUSH, cpu_rst=1, rom_sel=0, rom_we=0, rx_ready=0, load_busy=0, load_done=0;
  - rom_addr=0, rom_wdata=0, words_loaded=0, byte_cnt=0;
  - flush counter=0, idle counter=0, synchroniser flops=0.
- load_req synchronisation: 2-FF synchroniser, then a rising-edge detect on the synchronised signal. Edge detection is edge-sensitive only; a switch held high does not retrigger.
- FLUSH:
  - cpu_rst=1, rom_sel=0.
  - Counts FLUSH_CYC cycles, then goes to RUN.
  - load_req edges are ignored.
- RUN:
  - cpu_rst=0, rom_sel=0, rx_ready=0.
  - A load_req rising edge moves to LOAD on the next cycle and clears rom_addr, byte_cnt, words_loaded and the idle counter.
- LOAD:
  - cpu_rst=1, rom_sel=1, rx_ready=1, load_busy=1.
  - On each accepted byte, byte number byte_cnt goes into rom_wdata[8*byte_cnt+7 -: 8] (little-endian), byte_cnt increments and the idle counter clears.
  - When the 4th byte is accepted, go to WRITE.
  - With no accepted byte the idle counter increments. When it reaches TIMEOUT and words_loaded>0, go to FLUSH. A partial word (byte_cnt≠0) is discarded, and load_done pulses.
  - With words_loaded==0 there is no timeout: wait indefinitely for the first word.
- WRITE (exactly 1 cycle):
  - rom_we=1 with rom_addr and rom_wdata stable; rx_ready=0 (upstream holds its byte).
  - Next cycle: byte_cnt=0 and words_loaded+1.
  - If rom_addr==WORDS-1, go to FLUSH with load_done pulse and rom_addr left at WORDS-1.
  - Otherwise rom_addr+1 and back to LOAD.
- rom_addr never wraps; the load terminates at WORDS words.
- Reset mid-LOAD/WRITE: immediate abort. No further writes; the ROM contents already written remain. Restart goes through FLUSH then RUN.
- All outputs are registered.
- Latency: rom_we is asserted 1 cycle after the 4th byte is accepted. cpu_rst falls FLUSH_CYC+1 cycles after load_done.

Test Plan:
1. Reset → cpu_rst=1 through reset and for FLUSH_CYC=4 cycles after release, then 0; rom_sel=0, rom_we never asserted.
2. RUN, pulse load_req, send bytes 78 56 34 12 EF BE AD DE, then idle TIMEOUT (set 20) → rom_we twice:
   - addr 0 data 0x12345678;
   - addr 1 data 0xDEADBEEF;
   - then load_done, words_loaded=2; cpu_rst=1 throughout, deasserts 5 cycles after load_done.
3. WORDS=2, stream 12 bytes → exactly 2 writes (addr 0,1), FLUSH entered right after the second WRITE; remaining bytes never accepted (rx_ready=0), rom_addr stays 1.
4. Send 1 full word then 2 bytes, idle TIMEOUT → 1 write only, words_loaded=1, partial bytes dropped; next load's first word lands at addr 0 with correct data.
5. rx_valid held high continuously → rx_ready drops for the WRITE cycle and no byte is lost or duplicated across words (check 3 consecutive words 0x03020100, 0x07060504, 0x0B0A0908).
6. Assert reset after 6 bytes of a load → outputs return to reset values immediately, only addr 0 was written; load_req held high across reset release does not start a load until toggled low→high.
